univ_shift_reg: RTL and testbench

//   Parametrised universal shift register that generalises the single-bit D flip-flop.
//   - WIDTH-bit registered state with eight modes: hold, logical shift R/L,

---
 rtl/univ_shift_reg.sv | 85 ++++++++
 tb/tb_univ_shift_reg.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//   Parametrised universal shift register. Holds WIDTH bits of registered state
//   and on each enabled rising edge applies one of eight operations: hold,
//   logical shift right/left, parallel load, rotate right/left, arithmetic
//   shift right, or clear. General storage/shift element for serializers,
//   deserializers and delay chains.
//
// Parameters
//   WIDTH    register width in bits (>= 2)
//   RST_VAL  value loaded into q on reset
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous reset, active-high (wins over en and mode)
//   en      clock enable; 0 holds q regardless of mode
//   mode    operation select (see MODE_* encodings below)
//   d       parallel load data
//   sin_l   serial in, enters MSB on logical shift right
//   sin_r   serial in, enters LSB on logical shift left
//   q       registered state
//   sout_r  q[0], the bit that leaves on the next right shift
//   sout_l  q[WIDTH-1], the bit that leaves on the next left shift
//   zero    q == 0, combinational from q
// -----------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             zero
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    logic [WIDTH-1:0] q_next;

    // Next-state select. Serial inputs are only referenced by the two logical
    // shift arms, so an undriven sin_l/sin_r cannot leak into other modes.
    always_comb begin
        q_next = q;
        unique case (mode)
            MODE_HOLD: q_next = q;
            MODE_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
            MODE_SHL:  q_next = {q[WIDTH-2:0], sin_r};
            MODE_LOAD: q_next = d;
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            // Clear goes to all-zeros, deliberately not RST_VAL.
            MODE_CLR:  q_next = '0;
            default:   q_next = q;
        endcase
    end

    // rst > en > mode
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= q_next;
        end
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];
    assign zero   = (q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
//   Directed bench for univ_shift_reg (WIDTH=8, RST_VAL=8'hA5). A table of
//   per-edge vectors with hand-computed q values, plus hand-written sequences
//   for the reset glitch and the serialize-with-mid-sequence-reset case.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int         W    = 8;
    localparam logic [7:0] RSTV = 8'hA5;

    logic         clk = 1'b0;
    logic         rst, en, sin_l, sin_r;
    logic [2:0]   mode;
    logic [W-1:0] d, q;
    logic         sout_r, sout_l, zero;

    int errors = 0;
    int checks = 0;

    univ_shift_reg #(.WIDTH(W), .RST_VAL(RSTV)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r),
        .q(q), .sout_r(sout_r), .sout_l(sout_l), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       rst;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sl;
        logic       sr;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic r, input logic e,
                       input logic [2:0] m, input logic [7:0] dd,
                       input logic sl, input logic sr, input logic [7:0] eq);
        vec_t v;
        v.nm = nm; v.rst = r; v.en = e; v.mode = m; v.d = dd;
        v.sl = sl; v.sr = sr; v.exp_q = eq;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Full output check against an expected q; sout/zero follow from it.
    task automatic chk_all(input string nm, input logic [7:0] exp);
        chk({nm, ".q"}, q, exp);
        chk({nm, ".sout_r"}, {7'd0, sout_r}, {7'd0, exp[0]});
        chk({nm, ".sout_l"}, {7'd0, sout_l}, {7'd0, exp[7]});
        chk({nm, ".zero"}, {7'd0, zero}, {7'd0, (exp == 8'h00)});
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] m,
                         input logic [7:0] dd, input logic sl, input logic sr);
        rst = r; en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
    endtask

    initial begin
        logic [7:0] ser;
        drive(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);

        //   name          rst en  mode    d      sl  sr  exp q
        add("reset",       1, 0, 3'b000, 8'h00, 0, 0, 8'hA5);
        add("load3C",      0, 1, 3'b011, 8'h3C, 0, 0, 8'h3C);
        add("en0_a",       0, 0, 3'b011, 8'hFF, 0, 0, 8'h3C);
        add("en0_b",       0, 0, 3'b011, 8'hFF, 0, 0, 8'h3C);
        add("en0_c",       0, 0, 3'b011, 8'hFF, 0, 0, 8'h3C);
        add("hold",        0, 1, 3'b000, 8'hFF, 1, 1, 8'h3C);
        add("load81",      0, 1, 3'b011, 8'h81, 0, 0, 8'h81);
        add("shr1",        0, 1, 3'b001, 8'h00, 0, 0, 8'h40);
        add("shr2",        0, 1, 3'b001, 8'h00, 0, 0, 8'h20);
        add("shl1",        0, 1, 3'b010, 8'h00, 0, 1, 8'h41);
        add("shl2",        0, 1, 3'b010, 8'h00, 0, 1, 8'h83);
        add("shr_sin1",    0, 1, 3'b001, 8'h00, 1, 0, 8'hC1);
        add("load01",      0, 1, 3'b011, 8'h01, 0, 0, 8'h01);
        add("ror",         0, 1, 3'b100, 8'h00, 0, 0, 8'h80);
        add("load96",      0, 1, 3'b011, 8'h96, 0, 0, 8'h96);
        // serial inputs held at 1 while rotating: must be ignored
        add("rol1",        0, 1, 3'b101, 8'h00, 1, 1, 8'h2D);
        add("rol2",        0, 1, 3'b101, 8'h00, 1, 1, 8'h5A);
        add("rol3",        0, 1, 3'b101, 8'h00, 1, 1, 8'hB4);
        add("rol4",        0, 1, 3'b101, 8'h00, 1, 1, 8'h69);
        add("rol5",        0, 1, 3'b101, 8'h00, 1, 1, 8'hD2);
        add("rol6",        0, 1, 3'b101, 8'h00, 1, 1, 8'hA5);
        add("rol7",        0, 1, 3'b101, 8'h00, 1, 1, 8'h4B);
        add("rol8",        0, 1, 3'b101, 8'h00, 1, 1, 8'h96);
        add("load90",      0, 1, 3'b011, 8'h90, 0, 0, 8'h90);
        add("asr1",        0, 1, 3'b110, 8'h00, 0, 0, 8'hC8);
        add("asr2",        0, 1, 3'b110, 8'h00, 0, 0, 8'hE4);
        add("asr3",        0, 1, 3'b110, 8'h00, 0, 0, 8'hF2);
        add("clear",       0, 1, 3'b111, 8'h00, 1, 1, 8'h00);
        add("loadFF",      0, 1, 3'b011, 8'hFF, 0, 0, 8'hFF);
        add("asr_ones",    0, 1, 3'b110, 8'h00, 0, 0, 8'hFF);
        add("load40",      0, 1, 3'b011, 8'h40, 0, 0, 8'h40);
        add("asr_pos",     0, 1, 3'b110, 8'h00, 1, 1, 8'h20);
        add("rst_over_en", 1, 0, 3'b111, 8'h00, 0, 0, 8'hA5);

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sl, vecs[i].sr);
            @(posedge clk); #1;
            chk_all(vecs[i].nm, vecs[i].exp_q);
            @(negedge clk);
        end

        // rst pulse between edges has no effect
        drive(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk_all("rst_glitch", 8'hA5);

        // serialize 8'hB4 LSB first, rst on the 4th shifting edge
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b011, 8'hB4, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_all("ser_load", 8'hB4);
        ser = 8'hB4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(k == 3, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
            chk($sformatf("ser_sout%0d", k), {7'd0, sout_r}, {7'd0, ser[k]});
            @(posedge clk); #1;
        end
        chk_all("ser_rst", 8'hA5);
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_all("ser_resume", 8'h52);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
